main_memory_responder: RTL

- Block-granular main-memory model and responder on the memory side of the direct-mapped cache's memory handshake.
- Serves refill reads (read_en_mem → valid_mem + data_out_mem) and accepts dirty write-backs (write_en_mem qualified by ready_mem).
- Programmable read and write latencies.
- Sits in the cache top level beside cache_controller and cache_memory, and replaces the external memory stimulus on ready_mem / valid_mem / data_out_mem.

---
 rtl/main_memory_responder.sv | 111 +++++++++++
 1 files changed

// File: rtl/main_memory_responder.sv
// Block-granular main-memory model answering the cache controller's refill
// reads and dirty write-backs, with programmable read/write latencies.
module main_memory_responder #(
  parameter int unsigned WORD_SIZE       = 32,
  parameter int unsigned WORDS_PER_BLOCK = 4,
  parameter int unsigned BLOCK_SIZE      = WORD_SIZE * WORDS_PER_BLOCK,
  parameter int unsigned ADDR_WIDTH      = 30,
  parameter int unsigned MEM_DEPTH       = 1024,
  parameter int unsigned READ_LATENCY    = 4,
  parameter int unsigned WRITE_LATENCY   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read_en_mem,
  input  logic                  write_en_mem,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [BLOCK_SIZE-1:0] dirty_block_in,
  output logic                  ready_mem,
  output logic                  valid_mem,
  output logic [BLOCK_SIZE-1:0] data_out_mem,
  output logic                  proto_err
);

  localparam int unsigned ROW_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned CNT_MAX = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    READ_WAIT,
    READ_RESP,
    WRITE_BUSY
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               rd_armed;
  logic [ROW_W-1:0]   rd_row;
  logic [ROW_W-1:0]   row;
  logic               wr_acc, rd_acc;
  logic               unused_addr;

  logic [BLOCK_SIZE-1:0] mem [MEM_DEPTH] = '{default: '0};

  assign row         = mem_addr[ROW_W-1:0];
  assign unused_addr = ^mem_addr;

  // Acceptance is gated by the registered ready_mem, so nothing is taken in
  // a cycle where the controller was told the responder is busy.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    wr_acc  = 1'b0;
    rd_acc  = 1'b0;
    unique case (state)
      IDLE: begin
        if (ready_mem && write_en_mem) begin
          wr_acc = 1'b1;
          if (WRITE_LATENCY != 0) begin
            state_n = WRITE_BUSY;
            cnt_n   = CNT_W'(WRITE_LATENCY);
          end
        end else if (ready_mem && read_en_mem && rd_armed) begin
          rd_acc  = 1'b1;
          cnt_n   = CNT_W'(READ_LATENCY - 1);
          state_n = (READ_LATENCY == 1) ? READ_RESP : READ_WAIT;
        end
      end
      READ_WAIT: begin
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_n = READ_RESP;
      end
      READ_RESP: state_n = IDLE;
      WRITE_BUSY: begin
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered copies of the state, so valid_mem and a rising
  // ready_mem appear one edge after the state change that causes them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      ready_mem    <= 1'b0;
      valid_mem    <= 1'b0;
      data_out_mem <= '0;
      proto_err    <= 1'b0;
      rd_armed     <= 1'b1;
      rd_row       <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      ready_mem <= (state == IDLE) && (state_n == IDLE);
      valid_mem <= (state == READ_RESP);
      if (state == READ_RESP) data_out_mem <= mem[rd_row];
      if (write_en_mem && !ready_mem) proto_err <= 1'b1;
      if (!read_en_mem)  rd_armed <= 1'b1;
      else if (rd_acc)   rd_armed <= 1'b0;
      if (rd_acc) rd_row <= row;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc && !rst) mem[row] <= dirty_block_in;
  end

endmodule
